// File: rtl/count_capture_pkg.sv
// Shared defaults and the capture-word layout for count_capture.
package count_capture_pkg;

    localparam int CNT_W_DEF   = 4;
    localparam int EPOCH_W_DEF = 4;
    localparam int DEPTH_DEF   = 4;

    typedef struct packed {
        logic [EPOCH_W_DEF-1:0] epoch;
        logic [CNT_W_DEF-1:0]   count;
    } cap_word_t;

endpackage

// File: rtl/count_capture_fifo.sv
// First-word-fall-through capture FIFO; storage is not reset, pointers and level are.
module count_capture_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_req,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_req,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push, pop;

    always_comb begin
        pop      = pop_req && (level_q != '0);
        // A pop frees the slot this cycle, so a full FIFO still accepts the push.
        push     = push_req && ((level_q != LW'(DEPTH)) || pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (rst) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop)      level_d = level_q + LW'(1);
            else if (pop && !push) level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        level_q  <= level_d;
    end

    always_ff @(posedge clk) begin
        if (push && !rst) mem_q[wr_ptr_q] <= push_data;
    end

    assign out_data  = mem_q[rd_ptr_q];
    assign level     = level_q;
    assign full      = (level_q == LW'(DEPTH));
    assign empty     = (level_q == '0);
    assign out_valid = !empty;

endmodule

// File: rtl/count_capture.sv
// Epoch-extended counter capture into a FWFT FIFO.
// Define COUNT_CAPTURE_OVF_EN to add the sticky ovf flag and its ovf_clr input.
module count_capture
    import count_capture_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int EPOCH_W = EPOCH_W_DEF,
    parameter int DEPTH   = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CNT_W-1:0]           cnt_in,
    input  logic                       cap,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [EPOCH_W+CNT_W-1:0]   out_data,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       full,
    output logic                       empty
`ifdef COUNT_CAPTURE_OVF_EN
   ,input  logic                       ovf_clr,
    output logic                       ovf
`endif
);

    localparam int WORD_W = EPOCH_W + CNT_W;

    logic [CNT_W-1:0]   prev_q, prev_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic               wrap;
    logic [WORD_W-1:0]  word;

    always_comb begin
        // Only an all-ones -> zero step is a wrap; other drops to zero are upstream resets.
        wrap    = (prev_q == {CNT_W{1'b1}}) && (cnt_in == '0);
        epoch_d = epoch_q + (wrap ? EPOCH_W'(1) : EPOCH_W'(0));
        word    = {epoch_d, cnt_in};
        prev_d  = cnt_in;
        if (rst) begin
            epoch_d = '0;
            prev_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        prev_q  <= prev_d;
        epoch_q <= epoch_d;
    end

    count_capture_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_req  (cap),
        .push_data (word),
        .pop_req   (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .level     (level),
        .full      (full),
        .empty     (empty)
    );

`ifdef COUNT_CAPTURE_OVF_EN
    logic ovf_q, ovf_d;
    logic drop;

    always_comb begin
        // Full implies a valid head, so out_ready alone decides whether a pop makes room.
        drop  = cap && full && !out_ready;
        ovf_d = ovf_q;
        if (rst)          ovf_d = 1'b0;
        else if (drop)    ovf_d = 1'b1;
        else if (ovf_clr) ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_count_capture.sv
// Directed and randomized checks of count_capture against a queue-based reference model.
module tb_count_capture;
    import count_capture_pkg::*;

    localparam int CNT_W   = 4;
    localparam int EPOCH_W = 4;
    localparam int DEPTH   = 4;
    localparam int LW      = $clog2(DEPTH + 1);

    logic                     clk = 1'b0;
    logic                     rst, cap, out_ready, ovf_clr;
    logic [CNT_W-1:0]         cnt_in;
    logic                     out_valid, full, empty;
    logic [EPOCH_W+CNT_W-1:0] out_data;
    logic [LW-1:0]            level;
`ifdef COUNT_CAPTURE_OVF_EN
    logic                     ovf;
`endif

    count_capture #(.CNT_W(CNT_W), .EPOCH_W(EPOCH_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cnt_in    (cnt_in),
        .cap       (cap),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .full      (full),
        .empty     (empty)
`ifdef COUNT_CAPTURE_OVF_EN
       ,.ovf_clr   (ovf_clr),
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model: words are epoch*2^CNT_W + count held in a plain queue.
    int mq[$];
    int m_prev  = 0;
    int m_epoch = 0;
    bit m_ovf   = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic model_step();
        int  cmax, ep, word;
        bit  pop, push, drop;
        cmax = (1 << CNT_W) - 1;
        if (rst) begin
            mq.delete();
            m_prev  = 0;
            m_epoch = 0;
            m_ovf   = 0;
        end else begin
            ep   = (m_prev == cmax && int'(cnt_in) == 0) ? (m_epoch + 1) % (1 << EPOCH_W) : m_epoch;
            word = ep * (1 << CNT_W) + int'(cnt_in);
            pop  = out_ready && mq.size() > 0;
            push = cap && (mq.size() < DEPTH || pop);
            drop = cap && !push;
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back(word);
            if (drop)         m_ovf = 1;
            else if (ovf_clr) m_ovf = 0;
            m_epoch = ep;
            m_prev  = int'(cnt_in);
        end
    endtask

    task automatic check_all();
        chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        chk("level", 32'(level), 32'(mq.size()));
        chk("full", 32'(full), 32'(mq.size() == DEPTH));
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        if (mq.size() > 0) chk("out_data", 32'(out_data), 32'(mq[0]));
`ifdef COUNT_CAPTURE_OVF_EN
        chk("ovf", 32'(ovf), 32'(m_ovf));
`endif
    endtask

    task automatic drive(bit r, int c, bit cp, bit rd);
        rst       = r;
        cnt_in    = CNT_W'(c);
        cap       = cp;
        out_ready = rd;
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        cap_word_t w;
        int        rc;
        rst = 1'b1; cap = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0; cnt_in = '0;

        // Reset held two cycles
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
`ifdef COUNT_CAPTURE_OVF_EN
        chk("rst_ovf", 32'(ovf), 0);
`endif

        // Wrap 15 -> 0 bumps the epoch seen by a later capture
        drive(0, 14, 0, 0);
        drive(0, 15, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 1, 1, 0);
        w = '{epoch: 4'd1, count: 4'd1};
        chk("wrap_valid", 32'(out_valid), 1);
        chk("wrap_data", 32'(out_data), 32'(w));
        drive(0, 2, 0, 1);

        // Overflow: five captures into a four-deep FIFO with no consumer
        drive(1, 0, 0, 0);
        for (int i = 3; i <= 7; i++) drive(0, i, 1, 0);
        chk("ovf_level", 32'(level), 4);
        chk("ovf_full", 32'(full), 1);
`ifdef COUNT_CAPTURE_OVF_EN
        chk("ovf_set", 32'(ovf), 1);
`endif
        for (int k = 0; k < 4; k++) begin
            chk("ovf_drain", 32'(out_data), 32'(3 + k));
            drive(0, 8, 0, 1);
        end
        chk("ovf_drained_empty", 32'(empty), 1);
`ifdef COUNT_CAPTURE_OVF_EN
        ovf_clr = 1'b1;
        drive(0, 8, 0, 0);
        ovf_clr = 1'b0;
        chk("ovf_cleared", 32'(ovf), 0);
`endif

        // Capture while full with a simultaneous pop
        drive(1, 0, 0, 0);
        for (int i = 8; i <= 11; i++) drive(0, i, 1, 0);
        chk("fwp_pre_level", 32'(level), 4);
        drive(0, 12, 1, 1);
        chk("fwp_level", 32'(level), 4);
`ifdef COUNT_CAPTURE_OVF_EN
        chk("fwp_ovf", 32'(ovf), 0);
`endif
        for (int k = 0; k < 4; k++) begin
            chk("fwp_drain", 32'(out_data), 32'(9 + k));
            drive(0, 13, 0, 1);
        end

        // Sixteen wraps bring the epoch back to zero
        drive(1, 0, 0, 0);
        repeat (16) begin
            drive(0, 15, 0, 0);
            drive(0, 0, 0, 0);
        end
        drive(0, 2, 1, 0);
        chk("epoch_wrap_data", 32'(out_data), 32'h02);
        drive(0, 3, 0, 1);

        // Reset mid-stream with a capture in the same cycle
        drive(1, 0, 0, 0);
        drive(0, 15, 0, 0);
        drive(0, 0, 1, 0);
        drive(0, 1, 1, 0);
        drive(0, 2, 1, 0);
        chk("mid_pre_level", 32'(level), 3);
        drive(1, 3, 1, 0);
        chk("mid_level", 32'(level), 0);
        chk("mid_valid", 32'(out_valid), 0);
        drive(0, 5, 1, 0);
        chk("mid_epoch0", 32'(out_data), 32'h05);

        // Randomized traffic
        rc = 5;
        for (int n = 0; n < 400; n++) begin
            rc = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : (rc + 1) % 16;
            ovf_clr = ($urandom_range(0, 9) == 0);
            drive(($urandom_range(0, 49) == 0), rc, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 2) == 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
